// File: rtl/aes_pkg.sv
// Shared AES sequencing types: round-controller state encoding, key-size round
// counts and the default round index width.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    KWAIT = 3'd3,
    FIN   = 3'd4
  } aes_state_t;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  // Wide enough to hold round indices 0..14 for every key size.
  localparam int AES_RW = 4;

  // Phase counter width; a single-cycle round still needs one bit.
  function automatic int aes_phase_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control bundle between the round sequencer (master) and the wrapper/datapath (slave).
// The abort signal exists only when AES_ROUND_CTRL_ABORT_EN is defined.
interface aes_round_ctrl_if
  import aes_pkg::*;
#(
  parameter int RW = AES_RW
);

  logic          start;
  logic          E_D;
  logic          key_rdy;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic          abort;
`endif
  logic          busy;
  logic          done;
  logic          ed_q;
  logic [RW-1:0] round;
  logic          key_req;
  logic          ld_sel;
  logic          st_en;
  logic          mix_byp;

`ifdef AES_ROUND_CTRL_ABORT_EN
  modport master (
    input  start, E_D, key_rdy, abort,
    output busy, done, ed_q, round, key_req, ld_sel, st_en, mix_byp
  );

  modport slave (
    output start, E_D, key_rdy, abort,
    input  busy, done, ed_q, round, key_req, ld_sel, st_en, mix_byp
  );
`else
  modport master (
    input  start, E_D, key_rdy,
    output busy, done, ed_q, round, key_req, ld_sel, st_en, mix_byp
  );

  modport slave (
    output start, E_D, key_rdy,
    input  busy, done, ed_q, round, key_req, ld_sel, st_en, mix_byp
  );
`endif

endinterface

// File: rtl/aes_round_phase_cnt.sv
// Per-round phase counter: counts datapath cycles 0..ROUND_LAT-1 and returns to
// zero only through load; flags phase zero and the terminal phase.
module aes_round_phase_cnt
  import aes_pkg::*;
#(
  parameter int ROUND_LAT = 4,
  parameter int PW        = aes_phase_w(ROUND_LAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc,
  output logic zero
);

  localparam logic [PW-1:0] LAST = PW'(ROUND_LAT - 1);

  logic [PW-1:0] phase_reg;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      phase_reg <= '0;
    end else if (en) begin
      phase_reg <= phase_reg + PW'(1);
    end
  end

  assign tc   = (phase_reg == LAST);
  assign zero = (phase_reg == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: initial AddRoundKey then NR rounds of ROUND_LAT
// cycles each, stalling on key_rdy. Optional abort via AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = AES_NR_128,
  parameter int ROUND_LAT = 4,
  parameter int RW        = AES_RW
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_round_ctrl_if.master     bus
);

  localparam int            PW   = aes_phase_w(ROUND_LAT);
  localparam logic [RW-1:0] NR_L = RW'(NR);

  aes_state_t    state_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          ed_q_reg;
  logic [RW-1:0] round_reg;

  logic ph_tc;
  logic ph_zero;
  logic ph_load;
  logic ph_en;
  logic step;
  logic init_go;
  logic abort_act;
  logic last_round;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_act = bus.abort &&
                     ((state_reg == INIT) || (state_reg == RUN) || (state_reg == KWAIT));
`else
  assign abort_act = 1'b0;
`endif

  assign init_go    = (state_reg == INIT) && bus.key_rdy;
  assign last_round = (round_reg == NR_L);

  // A round cycle executes unless phase 0 lacks its key; a waiting round resumes
  // in the very cycle the key arrives, so each missing-key cycle costs one cycle.
  assign step = ((state_reg == RUN)   && (!ph_zero || bus.key_rdy)) ||
                ((state_reg == KWAIT) && bus.key_rdy);

  assign ph_load = init_go || (step && ph_tc) || abort_act;
  assign ph_en   = step && !ph_tc;

  aes_round_phase_cnt #(
    .ROUND_LAT (ROUND_LAT),
    .PW        (PW)
  ) u_phase (
    .clk  (clk),
    .rst  (rst),
    .load (ph_load),
    .en   (ph_en),
    .tc   (ph_tc),
    .zero (ph_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ed_q_reg  <= 1'b1;
      round_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (abort_act) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        round_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              ed_q_reg  <= bus.E_D;
              round_reg <= '0;
              busy_reg  <= 1'b1;
              state_reg <= INIT;
            end
          end
          INIT: begin
            if (bus.key_rdy) begin
              round_reg <= RW'(1);
              state_reg <= RUN;
            end
          end
          RUN, KWAIT: begin
            if (!step) begin
              state_reg <= KWAIT;
            end else if (ph_tc && last_round) begin
              state_reg <= FIN;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              if (ph_tc) begin
                round_reg <= round_reg + RW'(1);
              end
            end
          end
          FIN: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.ed_q    = ed_q_reg;
  assign bus.round   = round_reg;
  assign bus.key_req = (state_reg == INIT) || (state_reg == RUN) || (state_reg == KWAIT);
  assign bus.ld_sel  = (state_reg == INIT);
  assign bus.st_en   = init_go || step;
  assign bus.mix_byp = last_round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl (NR=10, ROUND_LAT=4); abort cases run only
// when AES_ROUND_CTRL_ABORT_EN is defined.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  aes_round_ctrl_if #(.RW(4)) bus ();

  aes_round_ctrl #(
    .NR        (10),
    .ROUND_LAT (4),
    .RW        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // {busy, done, ed_q, key_req, ld_sel, st_en, mix_byp, round[3:0]}
  localparam logic [10:0] RST_VEC = 11'b001_0000_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {bus.busy, bus.done, bus.ed_q, bus.key_req, bus.ld_sel,
            bus.st_en, bus.mix_byp, bus.round};
  endfunction

  // Expected outputs for an unstalled operation, c cycles after the start edge.
  function automatic logic [10:0] nom_vec(input int c, input logic ed);
    logic act;
    int   r;
    act = (c >= 1) && (c <= 41);
    if (c <= 1)       r = 0;
    else if (c >= 42) r = 10;
    else              r = (c - 2) / 4 + 1;
    return {act, (c == 42), ed, act, (c == 1), act, (r == 10), 4'(r)};
  endfunction

  // Key stalls at cycles 1..3 (INIT) and 21..22 (round 5, phase 0).
  function automatic logic stall_kr(input int c);
    return !((c >= 1 && c <= 3) || c == 21 || c == 22);
  endfunction

  function automatic logic [10:0] stall_vec(input int c);
    logic act;
    int   r;
    act = (c >= 1) && (c <= 46);
    if (c <= 4)       r = 0;
    else if (c <= 20) r = (c - 5) / 4 + 1;
    else if (c <= 22) r = 5;
    else if (c <= 46) r = (c - 23) / 4 + 5;
    else              r = 10;
    return {act, (c == 47), 1'b1, act, (c >= 1 && c <= 4),
            act && stall_kr(c), (r == 10), 4'(r)};
  endfunction

  task automatic begin_op(input logic ed);
    tick();
    bus.start = 1'b1;
    bus.E_D   = ed;
  endtask

  task automatic run_nominal(input string name, input logic ed, input bit toggle);
    begin_op(ed);
    for (int c = 1; c <= 42; c++) begin
      tick();
      bus.start = 1'b0;
      bus.E_D   = (toggle && c >= 10 && c <= 20) ? ~ed : ed;
      #2;
      check($sformatf("%s c%0d", name, c), 32'(obs()), 32'(nom_vec(c, ed)));
    end
    tick();
    bus.E_D = ed;
    #2;
    check($sformatf("%s idle busy/done", name), 32'({bus.busy, bus.done}), 32'd0);
    $display("op %s: ed=%0b ran 42 cycles", name, ed);
  endtask

  initial begin
    int low_cnt;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.E_D     = 1'b0;
    bus.key_rdy = 1'b1;
`ifdef AES_ROUND_CTRL_ABORT_EN
    bus.abort   = 1'b0;
`endif

    // Reset values while rst is held.
    tick();
    tick();
    #2;
    check("reset vec", 32'(obs()), 32'(RST_VEC));
    rst = 1'b0;
    tick();
    #2;
    check("idle after reset", 32'(obs()), 32'(RST_VEC));
    $display("op reset: outputs at reset values");

    run_nominal("enc", 1'b1, 1'b0);
    run_nominal("dec", 1'b0, 1'b1);

    // Key stalls: 3 cycles at INIT, 2 at phase 0 of round 5.
    low_cnt = 0;
    begin_op(1'b1);
    for (int c = 1; c <= 47; c++) begin
      tick();
      bus.start   = 1'b0;
      bus.key_rdy = stall_kr(c);
      #2;
      check($sformatf("stall c%0d", c), 32'(obs()), 32'(stall_vec(c)));
      if (c <= 46 && !bus.st_en) low_cnt++;
    end
    bus.key_rdy = 1'b1;
    check("stall st_en low count", 32'(low_cnt), 32'd5);
    tick();
    #2;
    check("stall idle busy/done", 32'({bus.busy, bus.done}), 32'd0);
    $display("op stall: done expected in cycle 47");

    // Start pulses at 10 and 42 are ignored; start at 43 runs a decrypt.
    begin_op(1'b1);
    for (int c = 1; c <= 85; c++) begin
      tick();
      bus.start = (c == 10 || c == 42 || c == 43);
      bus.E_D   = 1'b0;
      #2;
      if (c <= 42)
        check($sformatf("busy1 c%0d", c), 32'(obs()), 32'(nom_vec(c, 1'b1)));
      else if (c == 43)
        check("busy1 c43 idle", 32'({bus.busy, bus.done}), 32'd0);
      else
        check($sformatf("busy2 c%0d", c), 32'(obs()), 32'(nom_vec(c - 43, 1'b0)));
    end
    bus.start = 1'b0;
    tick();
    $display("op start-while-busy: second done expected in cycle 85");

    // Synchronous reset in cycle 20 of a decrypt.
    begin_op(1'b0);
    for (int c = 1; c <= 50; c++) begin
      tick();
      bus.start = 1'b0;
      rst       = (c == 20);
      #2;
      if (c <= 20)
        check($sformatf("rstmid c%0d", c), 32'(obs()), 32'(nom_vec(c, 1'b0)));
      else if (c == 21)
        check("rstmid c21 vec", 32'(obs()), 32'(RST_VEC));
      else
        check($sformatf("rstmid c%0d busy/done", c), 32'({bus.busy, bus.done}), 32'd0);
    end
    $display("op reset-mid: no done after reset");

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort during round 3, then abort held together with start in IDLE.
    begin_op(1'b1);
    for (int c = 1; c <= 53; c++) begin
      tick();
      bus.start = (c == 51);
      bus.abort = (c == 11 || c == 51);
      #2;
      if (c <= 11)
        check($sformatf("abort c%0d", c), 32'(obs()), 32'(nom_vec(c, 1'b1)));
      else if (c == 12)
        check("abort c12 vec", 32'(obs()), 32'(RST_VEC));
      else if (c <= 51)
        check($sformatf("abort c%0d busy/done", c), 32'({bus.busy, bus.done}), 32'd0);
      else if (c == 52)
        check("abort+start accepted", 32'(obs()), 32'(nom_vec(1, 1'b1)));
      else
        check("abort+start c53", 32'(obs()), 32'(nom_vec(2, 1'b1)));
    end
    bus.abort = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("op abort: cancelled without done, start with abort accepted");
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
